// File: rtl/rotr16_pkg.sv
// Shared definitions for the rotate-right load controller: FSM state type and
// the default word / rotate-amount widths.
package rotr16_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int AMT_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ROTATE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/rotr16_ref_rot.sv
// Combinational reference rotator: word rotated right by amt positions.
// Instantiated by the controller only when ROTR16_LOAD_CTRL_CHECK_EN is defined.
module rotr16_ref_rot
    import rotr16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic [WIDTH-1:0] word,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] rot
);

    // For amt == 0 the left shift is by WIDTH, which yields zero.
    assign rot = (word >> amt) | (word << (WIDTH - int'(amt)));

endmodule

// File: rtl/rotr16_load_ctrl.sv
// Load controller for an external rotate-right register: loads a word, waits
// amt rotate steps, then captures and holds the result with valid/ready.
// Optional self-check enabled by defining ROTR16_LOAD_CTRL_CHECK_EN.
module rotr16_load_ctrl
    import rotr16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_word,
    input  logic [AMT_W-1:0] i_in_amt,
    output logic [WIDTH-1:0] o_rot_din,
    output logic             o_rot_load,
    input  logic [WIDTH-1:0] i_rot_dout,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_word,
    output logic             o_err
);

    state_t           state_q;
    logic [AMT_W-1:0] cnt_q;
    logic [AMT_W-1:0] amt_q;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] out_word_q;
    logic             capture;

    assign capture = (state_q == ST_ROTATE) && (cnt_q == '0);

    // NOTE: reset is sampled on the clock edge (synchronous), and all state
    // uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            amt_q      <= '0;
            word_q     <= '0;
            out_word_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_in_valid) begin
                        word_q  <= i_in_word;
                        amt_q   <= i_in_amt;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt_q   <= amt_q;
                    state_q <= ST_ROTATE;
                end
                ST_ROTATE: begin
                    if (capture) begin
                        out_word_q <= i_rot_dout;
                        state_q    <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - AMT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (i_out_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_in_ready  = (state_q == ST_IDLE);
    assign o_out_valid = (state_q == ST_HOLD);
    assign o_out_word  = out_word_q;
    assign o_rot_load  = (state_q == ST_LOAD);
    assign o_rot_din   = o_rot_load ? word_q : '0;

`ifdef ROTR16_LOAD_CTRL_CHECK_EN
    logic [WIDTH-1:0] exp_word;
    logic             err_q;

    rotr16_ref_rot #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_ref_rot (
        .word (word_q),
        .amt  (amt_q),
        .rot  (exp_word)
    );

    // Sticky: once a mismatch is seen only reset clears it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else if (capture && (i_rot_dout != exp_word)) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule
